tex_coord_multi_transform: RTL and testbench

- Next-generation XF texture-coordinate transform sequencer.
- Accepts a bundle of up to NUM_CHANNELS texcoords and transforms each enabled channel, in ascending channel order, by a 3x4 matrix fetched from position-matrix memory.
- Optionally applies a second post-transform matrix per channel (dual transform).
- Arithmetic is delegated to an external float dot-product unit; this block is the fetch/sequence/buffer controller.

---
 rtl/tex_coord_multi_transform.sv | 274 +++++++++++++++++++++++++++
 tb/tb_tex_coord_multi_transform.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tex_coord_multi_transform.sv
// Texture-coordinate transform sequencer: fetches 3x4 matrix rows, drives an external
// dot-product unit once per row and assembles the per-channel results into a bundle.
module tex_coord_multi_transform #(
   parameter int NUM_CHANNELS = 8,
   parameter int ADDR_W       = 6
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [96*NUM_CHANNELS-1:0]       in_texcoord,
   input  logic [ADDR_W*NUM_CHANNELS-1:0]   in_mtx_idx,
   input  logic [ADDR_W*NUM_CHANNELS-1:0]   in_post_idx,
   input  logic [NUM_CHANNELS-1:0]          in_chan_en,
   input  logic [NUM_CHANNELS-1:0]          in_ab11,
   input  logic [NUM_CHANNELS-1:0]          in_st,
   input  logic [NUM_CHANNELS-1:0]          in_dual,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [96*NUM_CHANNELS-1:0]       out_texcoord,
   output logic [ADDR_W-1:0]                mat_addr,
   output logic [1:0]                       mat_row,
   output logic                             mat_en,
   input  logic [127:0]                     mat_data,
   input  logic                             mat_valid,
   output logic                             dot_req,
   output logic [127:0]                     dot_vec,
   output logic [127:0]                     dot_row,
   input  logic                             dot_valid,
   input  logic [31:0]                      dot_result
);
   localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [31:0] ONE = 32'h3f80_0000;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_FETCH  = 3'd2;
   localparam logic [2:0] S_DOT    = 3'd3;
   localparam logic [2:0] S_OUT    = 3'd4;

   logic [2:0]              state_q, state_d;
   logic [95:0]             tc_q   [NUM_CHANNELS];
   logic [95:0]             tc_d   [NUM_CHANNELS];
   logic [95:0]             res_q  [NUM_CHANNELS];
   logic [95:0]             res_d  [NUM_CHANNELS];
   logic [ADDR_W-1:0]       mtx_q  [NUM_CHANNELS];
   logic [ADDR_W-1:0]       mtx_d  [NUM_CHANNELS];
   logic [ADDR_W-1:0]       post_q [NUM_CHANNELS];
   logic [ADDR_W-1:0]       post_d [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] en_q, en_d, ab11_q, ab11_d, st_q, st_d, dual_q, dual_d;
   logic [NUM_CHANNELS-1:0] done_q, done_d;
   logic [IDX_W-1:0]        chan_q, chan_d;
   logic                    pass_q, pass_d;
   logic [127:0]            vec_q, vec_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [1:0]              row_q, row_d;
   logic                    mat_en_q, mat_en_d;
   logic                    dot_req_q, dot_req_d;
   logic [127:0]            crow_q [3];
   logic [127:0]            crow_d [3];
   logic [ADDR_W-1:0]       caddr_q, caddr_d;
   logic                    cvalid_q, cvalid_d;
   logic [31:0]             w_q [3];
   logic [31:0]             w_d [3];

   logic                    sel_found;
   logic [IDX_W-1:0]        sel_idx;
   logic [95:0]             sel_tc;
   logic [1:0]              last_row;

   always_comb begin
      state_d  = state_q;
      tc_d     = tc_q;
      res_d    = res_q;
      mtx_d    = mtx_q;
      post_d   = post_q;
      en_d     = en_q;
      ab11_d   = ab11_q;
      st_d     = st_q;
      dual_d   = dual_q;
      done_d   = done_q;
      chan_d   = chan_q;
      pass_d   = pass_q;
      vec_d    = vec_q;
      addr_d   = addr_q;
      row_d    = row_q;
      mat_en_d = mat_en_q;
      dot_req_d = dot_req_q;
      crow_d   = crow_q;
      caddr_d  = caddr_q;
      cvalid_d = cvalid_q;
      w_d      = w_q;

      // Lowest-numbered channel not yet written to the result buffer
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
         if (!done_q[k]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(k);
         end
      end
      sel_tc   = tc_q[sel_idx];
      last_row = (!pass_q && st_q[chan_q]) ? 2'd1 : 2'd2;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               for (int k = 0; k < NUM_CHANNELS; k++) begin
                  tc_d[k]   = in_texcoord[96*k +: 96];
                  mtx_d[k]  = in_mtx_idx[ADDR_W*k +: ADDR_W];
                  post_d[k] = in_post_idx[ADDR_W*k +: ADDR_W];
               end
               en_d     = in_chan_en;
               ab11_d   = in_ab11;
               st_d     = in_st;
               dual_d   = in_dual;
               done_d   = '0;
               cvalid_d = 1'b0;
               state_d  = S_SELECT;
            end
         end
         S_SELECT: begin
            if (!sel_found) begin
               state_d = S_OUT;
            end else if (!en_q[sel_idx]) begin
               res_d[sel_idx]  = sel_tc;
               done_d[sel_idx] = 1'b1;
            end else begin
               chan_d = sel_idx;
               pass_d = 1'b0;
               vec_d  = {sel_tc[95:64], sel_tc[63:32], ab11_q[sel_idx] ? ONE : sel_tc[31:0], ONE};
               addr_d = mtx_q[sel_idx];
               row_d  = 2'd0;
               if (cvalid_q && caddr_q == mtx_q[sel_idx]) begin
                  dot_req_d = 1'b1;
                  state_d   = S_DOT;
               end else begin
                  mat_en_d = 1'b1;
                  cvalid_d = 1'b0;
                  state_d  = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (!mat_en_q) begin
               mat_en_d = 1'b1;
            end else if (mat_valid) begin
               mat_en_d = 1'b0;
               for (int r = 0; r < 3; r++) begin
                  if (row_q == 2'(r)) crow_d[r] = mat_data;
               end
               if (row_q == 2'd2) begin
                  cvalid_d  = 1'b1;
                  caddr_d   = addr_q;
                  row_d     = 2'd0;
                  dot_req_d = 1'b1;
                  state_d   = S_DOT;
               end else begin
                  row_d = row_q + 2'd1;
               end
            end
         end
         S_DOT: begin
            if (!dot_req_q) begin
               dot_req_d = 1'b1;
            end else if (dot_valid) begin
               dot_req_d = 1'b0;
               for (int r = 0; r < 3; r++) begin
                  if (row_q == 2'(r)) w_d[r] = dot_result;
               end
               if (row_q == last_row) begin
                  // The st mode never computes row 2 on the first pass
                  if (last_row == 2'd1) w_d[2] = ONE;
                  if (!pass_q && dual_q[chan_q]) begin
                     pass_d = 1'b1;
                     vec_d  = {w_d[0], w_d[1], w_d[2], ONE};
                     addr_d = post_q[chan_q];
                     row_d  = 2'd0;
                     if (cvalid_q && caddr_q == post_q[chan_q]) begin
                        dot_req_d = 1'b1;
                        state_d   = S_DOT;
                     end else begin
                        mat_en_d = 1'b1;
                        cvalid_d = 1'b0;
                        state_d  = S_FETCH;
                     end
                  end else begin
                     res_d[chan_q]  = {w_d[0], w_d[1], w_d[2]};
                     done_d[chan_q] = 1'b1;
                     state_d        = S_SELECT;
                  end
               end else begin
                  row_d = row_q + 2'd1;
               end
            end
         end
         S_OUT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            tc_q[k]   <= '0;
            res_q[k]  <= '0;
            mtx_q[k]  <= '0;
            post_q[k] <= '0;
         end
         en_q      <= '0;
         ab11_q    <= '0;
         st_q      <= '0;
         dual_q    <= '0;
         done_q    <= '0;
         chan_q    <= '0;
         pass_q    <= 1'b0;
         vec_q     <= '0;
         addr_q    <= '0;
         row_q     <= '0;
         mat_en_q  <= 1'b0;
         dot_req_q <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            crow_q[r] <= '0;
            w_q[r]    <= '0;
         end
         caddr_q   <= '0;
         cvalid_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         tc_q      <= tc_d;
         res_q     <= res_d;
         mtx_q     <= mtx_d;
         post_q    <= post_d;
         en_q      <= en_d;
         ab11_q    <= ab11_d;
         st_q      <= st_d;
         dual_q    <= dual_d;
         done_q    <= done_d;
         chan_q    <= chan_d;
         pass_q    <= pass_d;
         vec_q     <= vec_d;
         addr_q    <= addr_d;
         row_q     <= row_d;
         mat_en_q  <= mat_en_d;
         dot_req_q <= dot_req_d;
         crow_q    <= crow_d;
         caddr_q   <= caddr_d;
         cvalid_q  <= cvalid_d;
         w_q       <= w_d;
      end
   end

   always_comb begin
      dot_row = crow_q[0];
      if (row_q == 2'd1) dot_row = crow_q[1];
      if (row_q == 2'd2) dot_row = crow_q[2];
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         out_texcoord[96*k +: 96] = res_q[k];
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_OUT);
   assign mat_addr  = addr_q;
   assign mat_row   = row_q;
   assign mat_en    = mat_en_q;
   assign dot_req   = dot_req_q;
   assign dot_vec   = vec_q;

endmodule

// File: tb/tb_tex_coord_multi_transform.sv
// Bench for tex_coord_multi_transform: models matrix memory and dot unit, predicts each
// result bundle with real arithmetic and checks handshakes, stalls and reset abort.
module tb_tex_coord_multi_transform;
   localparam int N = 8;
   localparam int AW = 6;
   localparam logic [31:0] F0  = 32'h0000_0000;
   localparam logic [31:0] F05 = 32'h3f00_0000;
   localparam logic [31:0] F1  = 32'h3f80_0000;
   localparam logic [31:0] F2  = 32'h4000_0000;
   localparam logic [31:0] F3  = 32'h4040_0000;
   localparam logic [31:0] F4  = 32'h4080_0000;
   localparam logic [31:0] F6  = 32'h40c0_0000;
   localparam logic [31:0] F7  = 32'h40e0_0000;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [96*N-1:0]   in_texcoord;
   logic [AW*N-1:0]   in_mtx_idx;
   logic [AW*N-1:0]   in_post_idx;
   logic [N-1:0]      in_chan_en, in_ab11, in_st, in_dual;
   logic              out_valid;
   logic              out_ready;
   logic [96*N-1:0]   out_texcoord;
   logic [AW-1:0]     mat_addr;
   logic [1:0]        mat_row;
   logic              mat_en;
   logic [127:0]      mat_data;
   logic              mat_valid;
   logic              dot_req;
   logic [127:0]      dot_vec;
   logic [127:0]      dot_row;
   logic              dot_valid;
   logic [31:0]       dot_result;

   tex_coord_multi_transform #(.NUM_CHANNELS(N), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_texcoord(in_texcoord), .in_mtx_idx(in_mtx_idx), .in_post_idx(in_post_idx),
      .in_chan_en(in_chan_en), .in_ab11(in_ab11), .in_st(in_st), .in_dual(in_dual),
      .out_valid(out_valid), .out_ready(out_ready), .out_texcoord(out_texcoord),
      .mat_addr(mat_addr), .mat_row(mat_row), .mat_en(mat_en),
      .mat_data(mat_data), .mat_valid(mat_valid),
      .dot_req(dot_req), .dot_vec(dot_vec), .dot_row(dot_row),
      .dot_valid(dot_valid), .dot_result(dot_result)
   );

   initial forever #5 clk = ~clk;

   logic [127:0] mem [64][3];
   logic [95:0]  b_tc [N];
   logic [5:0]   b_mtx [N];
   logic [5:0]   b_post [N];
   logic [N-1:0] b_en, b_ab11, b_st, b_dual;

   logic [96*N-1:0] exp_out, got_out, in_pack;
   logic [127:0]    first_vec;
   int pass_cnt = 0, total_cnt = 0;
   int reads = 0, dots = 0, exp_reads = 0, exp_dots = 0;
   int mat_delay = 0, dot_delay = 0;
   logic dot_noise = 1'b0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      total_cnt++;
      if (got === want) pass_cnt++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
   endtask

   function automatic real sp2r(input logic [31:0] b);
      real m;
      int  e;
      e = int'(b[30:23]);
      if (e == 0) return 0.0;
      m = 1.0 + $itor(b[22:0]) / 8388608.0;
      while (e > 127) begin m = m * 2.0; e--; end
      while (e < 127) begin m = m / 2.0; e++; end
      return b[31] ? -m : m;
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      int e;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] dotp(input logic [127:0] v, input logic [127:0] r);
      real acc;
      acc = 0.0;
      for (int i = 0; i < 4; i++) acc += sp2r(v[127-32*i -: 32]) * sp2r(r[127-32*i -: 32]);
      return r2sp(acc);
   endfunction

   // Matrix memory responder with configurable latency
   initial begin : mat_resp
      int wait_n;
      logic pend;
      logic [7:0] op_s;
      mat_valid = 1'b0; mat_data = '0; pend = 1'b0; wait_n = 0; op_s = '0;
      forever begin
         @(negedge clk);
         if (mat_en === 1'b1) begin
            chk("no_dot_during_fetch", 128'(dot_req), 128'(0));
            if (!pend) begin
               pend = 1'b1; wait_n = 0; op_s = {mat_addr, mat_row};
            end else begin
               chk("mat_operand_stable", 128'({mat_addr, mat_row}), 128'(op_s));
            end
            if (wait_n >= mat_delay) begin
               mat_valid = 1'b1; mat_data = mem[mat_addr][mat_row]; reads++; pend = 1'b0;
            end else begin
               mat_valid = 1'b0; wait_n++;
            end
         end else begin
            mat_valid = 1'b0; pend = 1'b0;
         end
      end
   end

   // Dot-product responder; optional spurious valids while no request is open
   initial begin : dot_resp
      int wait_n;
      logic pend;
      logic [127:0] v_s, r_s;
      dot_valid = 1'b0; dot_result = '0; pend = 1'b0; wait_n = 0; v_s = '0; r_s = '0;
      forever begin
         @(negedge clk);
         if (dot_req === 1'b1) begin
            if (!pend) begin
               pend = 1'b1; wait_n = 0; v_s = dot_vec; r_s = dot_row;
            end else begin
               chk("dot_vec_stable", dot_vec, v_s);
               chk("dot_row_stable", dot_row, r_s);
            end
            if (wait_n >= dot_delay) begin
               if (dots == 0) first_vec = dot_vec;
               dot_valid = 1'b1; dot_result = dotp(dot_vec, dot_row); dots++; pend = 1'b0;
            end else begin
               dot_valid = 1'b0; wait_n++;
            end
         end else begin
            pend = 1'b0;
            dot_valid = dot_noise;
            dot_result = 32'h7fc0_dead;
         end
      end
   end

   // Result bundle must match the model on every cycle it is held
   initial begin : out_compare
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            total_cnt++;
            if (out_texcoord === exp_out) pass_cnt++;
            else $display("[TB] FAIL out_texcoord: got %h, expected %h", out_texcoord, exp_out);
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic compute_expected();
      logic cv;
      int ca, addr;
      logic [127:0] v;
      logic [31:0] w [3];
      cv = 1'b0; ca = 0; exp_reads = 0; exp_dots = 0;
      for (int k = 0; k < N; k++) begin
         if (!b_en[k]) begin
            exp_out[96*k +: 96] = b_tc[k];
            continue;
         end
         v = {b_tc[k][95:64], b_tc[k][63:32], b_ab11[k] ? F1 : b_tc[k][31:0], F1};
         addr = int'(b_mtx[k]);
         for (int p = 0; p < (b_dual[k] ? 2 : 1); p++) begin
            if (!(cv && ca == addr)) exp_reads += 3;
            cv = 1'b1; ca = addr;
            for (int r = 0; r < 3; r++) w[r] = dotp(v, mem[addr][r]);
            if (p == 0 && b_st[k]) begin
               w[2] = F1; exp_dots += 2;
            end else begin
               exp_dots += 3;
            end
            v = {w[0], w[1], w[2], F1};
            addr = int'(b_post[k]);
         end
         exp_out[96*k +: 96] = {w[0], w[1], w[2]};
      end
   endtask

   task automatic set_mat(input int a, input logic [127:0] r0, input logic [127:0] r1, input logic [127:0] r2);
      mem[a][0] = r0; mem[a][1] = r1; mem[a][2] = r2;
   endtask

   task automatic clear_bundle(input int seed);
      for (int k = 0; k < N; k++) begin
         b_tc[k]   = {32'h1100_0000 + 32'(seed*16 + k), 32'h2200_0000 + 32'(seed*16 + k), 32'h3300_0000 + 32'(seed*16 + k)};
         b_mtx[k]  = 6'(k + 20);
         b_post[k] = 6'(k + 40);
      end
      b_en = '0; b_ab11 = '0; b_st = '0; b_dual = '0;
   endtask

   task automatic set_chan(input int k, input logic [31:0] s, input logic [31:0] t, input logic [31:0] u,
                           input int mtx, input int post, input logic ab11, input logic st, input logic dual);
      b_tc[k] = {s, t, u}; b_mtx[k] = 6'(mtx); b_post[k] = 6'(post);
      b_en[k] = 1'b1; b_ab11[k] = ab11; b_st[k] = st; b_dual[k] = dual;
   endtask

   task automatic applyStimulus();
      int n;
      compute_expected();
      reads = 0; dots = 0; first_vec = '0;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         in_pack[96*k +: 96] = b_tc[k];
         in_mtx_idx[AW*k +: AW]  = b_mtx[k];
         in_post_idx[AW*k +: AW] = b_post[k];
      end
      in_texcoord = in_pack;
      in_chan_en = b_en; in_ab11 = b_ab11; in_st = b_st; in_dual = b_dual;
      in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("capture_ready", 128'(in_ready), 128'(1));
      @(negedge clk);
      in_valid = 1'b0;
      chk("in_ready_drop", 128'(in_ready), 128'(0));
   endtask

   task automatic checkOutput(input int stall);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      chk("out_valid_arrives", 128'(out_valid), 128'(1));
      if (out_valid !== 1'b1) return;
      for (int i = 0; i < stall; i++) begin
         chk("in_ready_during_stall", 128'(in_ready), 128'(0));
         @(negedge clk);
      end
      got_out = out_texcoord;
      out_ready = 1'b1;
      chk("in_ready_at_accept", 128'(in_ready), 128'(0));
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_drop", 128'(out_valid), 128'(0));
      chk("in_ready_return", 128'(in_ready), 128'(1));
      chk("mat_reads", 128'(reads), 128'(exp_reads));
      chk("dot_handshakes", 128'(dots), 128'(exp_dots));
   endtask

   initial begin : main
      int n;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_texcoord = '0; in_mtx_idx = '0; in_post_idx = '0;
      in_chan_en = '0; in_ab11 = '0; in_st = '0; in_dual = '0;
      for (int a = 0; a < 64; a++) for (int r = 0; r < 3; r++) mem[a][r] = '0;
      set_mat(0, {F1, F0, F0, F0}, {F0, F1, F0, F0}, {F0, F0, F1, F0});
      set_mat(1, {F1, F0, F0, F0}, {F0, F1, F0, F0}, {F0, F0, F1, 32'h40a0_0000});
      set_mat(2, {F2, F0, F0, F0}, {F0, F2, F0, F0}, {F0, F0, F2, F0});
      set_mat(3, {F1, F0, F0, F1}, {F0, F1, F0, F1}, {F0, F0, F1, F1});
      set_mat(5, {F1, F0, F0, F05}, {F0, F1, F0, F0}, {F0, F0, F1, F0});

      repeat (3) @(negedge clk);
      chk("reset_in_ready", 128'(in_ready), 128'(1));
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_mat_en", 128'(mat_en), 128'(0));
      chk("reset_dot_req", 128'(dot_req), 128'(0));
      chk("reset_out_zero", 128'(|out_texcoord), 128'(0));
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] single pass identity");
      clear_bundle(1);
      set_chan(0, F2, F3, F4, 0, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus();
      checkOutput(0);
      chk("identity_ch0", 128'(got_out[95:0]), 128'(96'h40000000_40400000_40800000));
      chk("identity_passthrough_ch5", 128'(got_out[96*5 +: 96]), 128'(b_tc[5]));
      chk("identity_reads", 128'(reads), 128'(3));
      chk("identity_dots", 128'(dots), 128'(3));

      $display("[TB] ab11 + st");
      clear_bundle(2);
      set_chan(0, F2, F3, F4, 1, 0, 1'b1, 1'b1, 1'b0);
      applyStimulus();
      checkOutput(0);
      chk("ab11_vec_z", 128'(first_vec[63:32]), 128'(F1));
      chk("st_ch0", 128'(got_out[95:0]), 128'(96'h40000000_40400000_3f800000));
      chk("st_dots", 128'(dots), 128'(2));

      $display("[TB] dual transform");
      clear_bundle(3);
      set_chan(0, F1, F2, F3, 2, 3, 1'b0, 1'b0, 1'b1);
      applyStimulus();
      checkOutput(0);
      chk("dual_ch0", 128'(got_out[95:0]), 128'(96'h40400000_40a00000_40e00000));
      chk("dual_reads", 128'(reads), 128'(6));
      chk("dual_dots", 128'(dots), 128'(6));

      $display("[TB] cache hit");
      clear_bundle(4);
      set_chan(0, F1, F2, F3, 5, 0, 1'b0, 1'b0, 1'b0);
      set_chan(1, F2, F3, F4, 5, 0, 1'b0, 1'b0, 1'b0);
      set_chan(2, F4, F2, F1, 5, 0, 1'b0, 1'b0, 1'b0);
      set_chan(3, F05, F1, F2, 5, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus();
      checkOutput(0);
      chk("cache_ch0", 128'(got_out[95:0]), 128'(96'h3fc00000_40000000_40400000));
      chk("cache_reads", 128'(reads), 128'(3));
      applyStimulus();
      checkOutput(0);
      chk("cache_reads_second_bundle", 128'(reads), 128'(3));

      $display("[TB] backpressure and stalls");
      mat_delay = 4; dot_delay = 7; dot_noise = 1'b1;
      clear_bundle(5);
      set_chan(0, F1, F2, F3, 2, 0, 1'b0, 1'b0, 1'b0);
      set_chan(2, F2, F3, F7, 5, 3, 1'b1, 1'b0, 1'b1);
      set_chan(4, F4, F05, F6, 1, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus();
      checkOutput(10);
      chk("stall_ch2", 128'(got_out[96*2 +: 96]), 128'(96'h40600000_40800000_40000000));
      mat_delay = 0; dot_delay = 0; dot_noise = 1'b0;

      $display("[TB] reset mid-operation");
      dot_delay = 3;
      clear_bundle(6);
      set_chan(0, F1, F2, F3, 0, 0, 1'b0, 1'b0, 1'b0);
      set_chan(1, F2, F3, F4, 2, 0, 1'b0, 1'b0, 1'b0);
      set_chan(2, F3, F4, F1, 5, 0, 1'b0, 1'b0, 1'b0);
      set_chan(3, F4, F1, F2, 3, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus();
      n = 0;
      while (!(dots == 6 && dot_req === 1'b1) && n < 2000) begin @(negedge clk); n++; end
      chk("reach_ch2_dot", 128'(dot_req), 128'(1));
      #1 reset = 1'b1;
      #1;
      chk("abort_mat_en", 128'(mat_en), 128'(0));
      chk("abort_dot_req", 128'(dot_req), 128'(0));
      chk("abort_out_valid", 128'(out_valid), 128'(0));
      chk("abort_in_ready", 128'(in_ready), 128'(1));
      chk("abort_out_zero", 128'(|out_texcoord), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      dot_delay = 0;

      clear_bundle(7);
      set_chan(0, F2, F05, F3, 5, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus();
      checkOutput(0);
      chk("post_reset_ch0", 128'(got_out[95:0]), 128'(96'h40200000_3f000000_40400000));
      chk("post_reset_reads", 128'(reads), 128'(3));

      $display("[TB] all channels disabled");
      clear_bundle(8);
      applyStimulus();
      checkOutput(2);
      chk("disabled_lo", got_out[127:0], in_pack[127:0]);
      chk("disabled_hi", got_out[767:640], in_pack[767:640]);
      chk("disabled_reads", 128'(reads), 128'(0));
      chk("disabled_dots", 128'(dots), 128'(0));

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
